// File: rtl/apb_pkg.sv
// apb_pkg: shared definitions for the apb_master_nslv requester.
// Latency: n/a (constants, types and an elaboration-time helper only).
// Backpressure: n/a.
// Contents: one-hot FSM state encoding, the slave-select width helper and the
// response cause codes, which identify why rsp_err was raised.
package apb_pkg;

  // One-hot FSM state encoding.
  localparam logic [2:0] ST_IDLE   = 3'b001;
  localparam logic [2:0] ST_SETUP  = 3'b010;
  localparam logic [2:0] ST_ACCESS = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_SETUP  = ST_SETUP,
    S_ACCESS = ST_ACCESS
  } apb_state_e;

  // Response cause codes. rsp_err is 1 for every cause except RSP_OK.
  localparam logic [1:0] RSP_OK      = 2'd0;
  localparam logic [1:0] RSP_SLVERR  = 2'd1;
  localparam logic [1:0] RSP_DECERR  = 2'd2;
  localparam logic [1:0] RSP_TIMEOUT = 2'd3;

  // Width of the slave index field taken from the top of the address.
  // The field is always at least one bit wide, even when NUM_SLV is 1.
  function automatic int sel_w(input int num_slv);
    return (num_slv <= 2) ? 1 : $clog2(num_slv);
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// apb_addr_decode: maps the top address bits to a one-hot slave select.
// Latency: purely combinational, zero cycles. Backpressure: none.
// Ports: addr_i (ADDR_W) in; sel_o (NUM_SLV, one-hot or all-zero) out;
//        dec_err_o out, set when the index addresses no slave.
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int NUM_SLV = 2
) (
  input  logic [ADDR_W-1:0]  addr_i,
  output logic [NUM_SLV-1:0] sel_o,
  output logic               dec_err_o
);

  localparam int SEL_W = sel_w(NUM_SLV);

  logic [SEL_W-1:0] idx;
  logic             unused_low;

  assign idx        = addr_i[ADDR_W-1 -: SEL_W];
  // Only the top bits select the slave. The bits below are offsets within that slave.
  assign unused_low = ^addr_i[ADDR_W-SEL_W-1:0];

  always_comb begin
    sel_o     = '0;
    dec_err_o = (32'(idx) >= 32'(NUM_SLV));
    for (int i = 0; i < NUM_SLV; i++) begin
      sel_o[i] = !dec_err_o && (32'(idx) == 32'(i));
    end
  end

endmodule

// File: rtl/apb_master_nslv.sv
// apb_master_nslv: valid/ready command port to an APB requester with NUM_SLV decoded selects.
// Latency: accept -> SETUP +1 -> ACCESS +2 -> rsp_valid +3 (with zero wait states). Back-to-back transfers run at 1 per 2 cycles.
// Backpressure: req_ready is 1 in IDLE and equals PREADY in ACCESS. rsp has no backpressure.
// Ports: PCLK/PRESETn; req_valid/req_ready/req_write/req_addr/req_wdata command;
//        rsp_valid/rsp_rdata/rsp_err response; PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA/PREADY/PSLVERR APB.
// Optional macro APB_MASTER_TIMEOUT_EN: abort the access after TIMEOUT_CYC ACCESS cycles without PREADY.
module apb_master_nslv
  import apb_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 8,
  parameter int NUM_SLV     = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [DATA_W-1:0]  req_wdata,
  output logic               rsp_valid,
  output logic [DATA_W-1:0]  rsp_rdata,
  output logic               rsp_err,
  output logic [NUM_SLV-1:0] PSEL,
  output logic               PENABLE,
  output logic               PWRITE,
  output logic [ADDR_W-1:0]  PADDR,
  output logic [DATA_W-1:0]  PWDATA,
  input  logic [DATA_W-1:0]  PRDATA,
  input  logic               PREADY,
  input  logic               PSLVERR
);

  if (NUM_SLV < 1 || NUM_SLV > 16 || ADDR_W < sel_w(NUM_SLV) + 1 ||
      TIMEOUT_CYC < 1 || TIMEOUT_CYC > 256) begin : g_param_chk
    $error("apb_master_nslv: illegal parameter combination");
  end

  logic [NUM_SLV-1:0] dec_sel;
  logic               dec_err;

  apb_addr_decode #(
    .ADDR_W  (ADDR_W),
    .NUM_SLV (NUM_SLV)
  ) u_dec (
    .addr_i    (req_addr),
    .sel_o     (dec_sel),
    .dec_err_o (dec_err)
  );

  apb_state_e         state_q;
  logic [NUM_SLV-1:0] psel_q;
  logic               penable_q;
  logic               pwrite_q;
  logic [ADDR_W-1:0]  paddr_q;
  logic [DATA_W-1:0]  pwdata_q;
  logic               rsp_valid_q;
  logic [DATA_W-1:0]  rsp_rdata_q;
  logic               rsp_err_q;
  // A decode error accepted at the same time as a completion. Its error
  // response is sent one cycle after the completion response.
  logic               decerr_pend_q;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] wait_cnt_q;
`endif

  logic accept;
  logic launch;

  // While a deferred decode-error response is waiting to go out, a second
  // decode error would need the same response slot. Such a command is held
  // off for that one cycle. Commands that decode correctly are still accepted.
  assign req_ready = ((state_q == S_IDLE) && !(decerr_pend_q && dec_err)) ||
                     ((state_q == S_ACCESS) && PREADY);
  assign accept    = req_valid && req_ready;
  assign launch    = accept && !dec_err;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= S_IDLE;
      psel_q        <= '0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      decerr_pend_q <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt_q    <= '0;
`endif
    end else begin
      // The response is a one-cycle pulse. All response fields drop back to 0 unless set again below.
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_rdata_q   <= '0;
      decerr_pend_q <= 1'b0;

      if (decerr_pend_q) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (accept && dec_err) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
          end
        end

        S_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= S_ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
        end

        S_ACCESS: begin
          if (PREADY) begin
            penable_q   <= 1'b0;
            psel_q      <= '0;
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= PSLVERR;
            rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
            if (accept && dec_err) begin
              decerr_pend_q <= 1'b1;
            end
          end
`ifdef APB_MASTER_TIMEOUT_EN
          else if (wait_cnt_q == TO_LAST) begin
            penable_q   <= 1'b0;
            psel_q      <= '0;
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
`endif
        end

        default: state_q <= S_IDLE;
      endcase

      // A new command that decodes correctly always starts a SETUP phase.
      // This happens from IDLE or directly from a completing ACCESS.
      // Assigning dec_sel leaves PSEL unchanged when the same slave is chosen again.
      if (launch) begin
        paddr_q   <= req_addr;
        pwrite_q  <= req_write;
        psel_q    <= dec_sel;
        penable_q <= 1'b0;
        state_q   <= S_SETUP;
        if (req_write) begin
          pwdata_q <= req_wdata;
        end
      end
    end
  end

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
